// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer; the timer side uses the slave modport.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             START;
  logic             STOP;
  logic             CE;
  logic             PERIODIC;
  logic [WIDTH-1:0] O;
  logic             BUSY;
  logic             EXPIRED;
  logic             DONE;
  logic             BOUT;

  modport master (
    output LOAD, D, START, STOP, CE, PERIODIC,
    input  O, BUSY, EXPIRED, DONE, BOUT
  );

  modport slave (
    input  LOAD, D, START, STOP, CE, PERIODIC,
    output O, BUSY, EXPIRED, DONE, BOUT
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot/periodic terminal count and cascade borrow-out.
// Optional prescaler on CE enabled by defining COUNTDOWN_TIMER_PRESCALE_EN.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  , parameter int unsigned PRESCALE = 4
`endif
) (
  input  logic               CLK,
  input  logic               RESET,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EXP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rld_q,   rld_d;
  logic             done_q,  done_d;
  logic             tick_c;
  logic             at_one_c;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  localparam int unsigned PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  logic [PS_W-1:0] ps_q, ps_d;
  assign tick_c = (ps_q == PS_LAST);
`else
  assign tick_c = 1'b1;
`endif

  assign at_one_c = (count_q == WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      ps_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      ps_q    <= ps_d;
`endif
    end
  end

  // Next state: LOAD beats STOP beats START beats CE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    ps_d    = ps_q;
`endif
    if (bus.LOAD) begin
      count_d = bus.D;
      rld_d   = bus.D;
      state_d = (bus.D != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      ps_d    = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.START && (count_q != '0)) begin
            state_d = RUN;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
            ps_d    = '0;
`endif
          end
        end
        RUN: begin
          if (bus.STOP) begin
            state_d = IDLE;
          end else if (bus.CE) begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
            ps_d = tick_c ? '0 : ps_q + PS_W'(1);
`endif
            if (tick_c) begin
              if (at_one_c) begin
                done_d = 1'b1;
                if (bus.PERIODIC) begin
                  count_d = rld_q;
                end else begin
                  count_d = '0;
                  state_d = EXP;
                end
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
        end
        EXP:     state_d = EXP;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.O       = count_q;
  assign bus.BUSY    = (state_q == RUN);
  assign bus.EXPIRED = (state_q == EXP);
  assign bus.DONE    = done_q;
  // Borrow is combinational from CE so cascaded stages see it in the same cycle.
  assign bus.BOUT    = (state_q == RUN) && bus.CE && at_one_c && tick_c;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected post-edge state is queued at drive time and checked after the edge.
module tb_countdown_timer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct {
    string      tag;
    logic [3:0] o;
    logic       busy;
    logic       expired;
    logic       done;
  } exp_t;

  exp_t sb[$];

  countdown_timer_if #(.WIDTH(4)) tif ();

  countdown_timer #(.WIDTH(4)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [3:0] got, input logic [3:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s.%s got=%0h exp=%0h", tag, field, got, expv);
    end
  endtask

  // Inputs are already set; check BOUT before the edge, queue and check registered state after it.
  task automatic tick(input string tag, input logic e_bout, input logic [3:0] e_o,
                      input logic e_busy, input logic e_exp, input logic e_done);
    exp_t e;
    exp_t g;
    #1;
    chk(tag, "bout", {3'b0, tif.BOUT}, {3'b0, e_bout});
    e.tag = tag; e.o = e_o; e.busy = e_busy; e.expired = e_exp; e.done = e_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk(tag, "sb_empty", 4'h1, 4'h0);
    end else begin
      g = sb.pop_front();
      chk(g.tag, "O",       tif.O,                 g.o);
      chk(g.tag, "BUSY",    {3'b0, tif.BUSY},    {3'b0, g.busy});
      chk(g.tag, "EXPIRED", {3'b0, tif.EXPIRED}, {3'b0, g.expired});
      chk(g.tag, "DONE",    {3'b0, tif.DONE},    {3'b0, g.done});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    tif.LOAD = 1'b0; tif.D = 4'd0; tif.START = 1'b0; tif.STOP = 1'b0;
    tif.CE = 1'b0; tif.PERIODIC = 1'b0;
    tick("rst_a", 0, 0, 0, 0, 0);
    tick("rst_b", 0, 0, 0, 0, 0);
    rst = 1'b0;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    // Prescale by 4: O holds each value for four enabled cycles.
    tif.LOAD = 1'b1; tif.D = 4'd2; tif.CE = 1'b1;
    tick("ps_ld", 0, 2, 1, 0, 0);
    tif.LOAD = 1'b0;
    for (int i = 0; i < 3; i++) tick("ps_hold2", 0, 2, 1, 0, 0);
    tick("ps_to1", 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick("ps_hold1", 0, 1, 1, 0, 0);
    tick("ps_to0", 1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) tick("ps_exp", 0, 0, 0, 1, 0);
`else
    // One-shot from 3.
    tif.LOAD = 1'b1; tif.D = 4'd3; tif.CE = 1'b1; tif.PERIODIC = 1'b0;
    tick("os_ld", 0, 3, 1, 0, 0);
    tif.LOAD = 1'b0;
    tick("os_2", 0, 2, 1, 0, 0);
    tick("os_1", 0, 1, 1, 0, 0);
    tick("os_0", 1, 0, 0, 1, 1);
    tick("os_exp", 0, 0, 0, 1, 0);
    tif.START = 1'b1;
    tick("os_start_ign", 0, 0, 0, 1, 0);
    tif.START = 1'b0;

    // Periodic from 2.
    tif.LOAD = 1'b1; tif.D = 4'd2; tif.PERIODIC = 1'b1;
    tick("pr_ld", 0, 2, 1, 0, 0);
    tif.LOAD = 1'b0;
    tick("pr_1a", 0, 1, 1, 0, 0);
    tick("pr_2a", 1, 2, 1, 0, 1);
    tick("pr_1b", 0, 1, 1, 0, 0);
    tick("pr_2b", 1, 2, 1, 0, 1);

    // Periodic with N=1: DONE continuously high.
    tif.LOAD = 1'b1; tif.D = 4'd1;
    tick("p1_ld", 0, 1, 1, 0, 0);
    tif.LOAD = 1'b0;
    tick("p1_a", 1, 1, 1, 0, 1);
    tick("p1_b", 1, 1, 1, 0, 1);

    // LOAD at terminal count wins: no DONE.
    tif.LOAD = 1'b1; tif.D = 4'd7; tif.PERIODIC = 1'b0;
    tick("ld_at_tc", 1, 7, 1, 0, 0);

    // Pause and resume.
    tif.D = 4'd9;
    tick("pz_ld", 0, 9, 1, 0, 0);
    tif.LOAD = 1'b0;
    tick("pz_8", 0, 8, 1, 0, 0);
    tick("pz_7", 0, 7, 1, 0, 0);
    tick("pz_6", 0, 6, 1, 0, 0);
    tick("pz_5", 0, 5, 1, 0, 0);
    tif.STOP = 1'b1;
    tick("pz_stop", 0, 5, 0, 0, 0);
    tif.STOP = 1'b0;
    for (int i = 0; i < 10; i++) tick("pz_hold", 0, 5, 0, 0, 0);
    tif.START = 1'b1;
    tick("pz_start", 0, 5, 1, 0, 0);
    tif.START = 1'b0;
    tick("pz_4", 0, 4, 1, 0, 0);

    // STOP coinciding with terminal count suppresses DONE.
    tick("tc_3", 0, 3, 1, 0, 0);
    tick("tc_2", 0, 2, 1, 0, 0);
    tick("tc_1", 0, 1, 1, 0, 0);
    tif.STOP = 1'b1;
    tick("tc_stop", 1, 1, 0, 0, 0);
    tif.STOP = 1'b0;
    tick("tc_idle", 0, 1, 0, 0, 0);

    // LOAD of zero stays IDLE and START cannot leave it.
    tif.LOAD = 1'b1; tif.D = 4'd0;
    tick("ld0", 0, 0, 0, 0, 0);
    tif.LOAD = 1'b0;
    tick("ld0_hold", 0, 0, 0, 0, 0);
    tif.START = 1'b1;
    tick("ld0_start", 0, 0, 0, 0, 0);
    tif.START = 1'b0;

    // Reset mid-count at 5.
    tif.LOAD = 1'b1; tif.D = 4'd5; tif.CE = 1'b0;
    tick("rs_ld", 0, 5, 1, 0, 0);
    tif.LOAD = 1'b0; tif.CE = 1'b1; rst = 1'b1;
    tick("rs_a", 0, 0, 0, 0, 0);
    tick("rs_b", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick("rs_post", 0, 0, 0, 0, 0);

    // Reset on a terminal-count edge drops the pending DONE.
    tif.LOAD = 1'b1; tif.D = 4'd1;
    tick("rd_ld", 0, 1, 1, 0, 0);
    tif.LOAD = 1'b0; rst = 1'b1;
    tick("rd_rst", 1, 0, 0, 0, 0);
    rst = 1'b0;
    tick("rd_post", 0, 0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
